// File: rtl/block_grid_memory.sv
// Brick-field store: ROWS x COLS cells with whole-grid sweeps, two read ports, a hit port and a live brick count.
// Optional build macro GRID_WRAP_EN: PULL/DROP rotate the grid instead of filling the vacated row with zeros.
module block_grid_memory #(
  parameter int ROWS   = 30,
  parameter int COLS   = 10,
  parameter int CELL_W = 3,
  parameter int ROW_AW = 5,
  parameter int COL_AW = 4,
  parameter int STG_W  = 2,
  parameter int CNT_W  = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               func,
  input  logic [STG_W-1:0]         stage,
  input  logic [ROW_AW-1:0]        row1,
  input  logic [COL_AW-1:0]        col1,
  input  logic [ROW_AW-1:0]        row2,
  input  logic [COL_AW-1:0]        col2,
  output logic [CELL_W-1:0]        block1,
  output logic [CELL_W-1:0]        block2,
  input  logic                     hit_valid,
  input  logic [ROW_AW-1:0]        hit_row,
  input  logic [COL_AW-1:0]        hit_col,
  output logic                     hit_ready,
  output logic                     destroyed,
  output logic [STG_W-1:0]         rom_stage,
  output logic [ROW_AW-1:0]        rom_row,
  input  logic [COLS*CELL_W-1:0]   rom_data,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         remaining,
  output logic                     cleared
);

  localparam logic [1:0]        FN_CLEAR   = 2'd0;
  localparam logic [1:0]        FN_LOAD    = 2'd1;
  localparam logic [1:0]        FN_PULL    = 2'd2;
  localparam logic [1:0]        FN_DROP    = 2'd3;
  localparam logic [CELL_W-1:0] CELL_SOLID = '1;
  localparam logic [ROW_AW-1:0] LAST_ROW   = ROW_AW'(ROWS - 1);

  typedef logic [COLS-1:0][CELL_W-1:0] row_t;
  typedef enum logic {ST_READY, ST_RUN} state_t;

  state_t             state_reg, state_next;
  logic [ROW_AW-1:0]  row_reg, row_next;
  logic               phase_reg, phase_next;
  logic [1:0]         func_reg, func_next;
  logic [STG_W-1:0]   stage_reg, stage_next;
  logic               done_reg, done_next;
  logic               accept;
  logic               last_row;

  wire  [ROWS-1:0][COLS-1:0][CELL_W-1:0] grid;
  row_t               src_row, vacant_row, wr_row, buf_reg;
  wire  [COLS-1:0]    live_col;
  logic [CNT_W-1:0]   row_pop;
  logic               row_we;

  logic [CNT_W-1:0]   acc_reg, remaining_reg;
  logic               destroyed_reg, cleared_reg;
  logic [CELL_W-1:0]  block1_reg, block2_reg;

  logic               hit_in, rd1_in, rd2_in;
  logic [CELL_W-1:0]  hit_cell;
  logic               hit_dec, hit_kill;

  assign busy      = (state_reg == ST_RUN);
  assign hit_ready = ~busy;
  assign done      = done_reg;
  assign rom_stage = stage_reg;
  assign rom_row   = busy ? row_reg : '0;
  assign remaining = remaining_reg;
  assign destroyed = destroyed_reg;
  assign cleared   = cleared_reg;
  assign block1    = block1_reg;
  assign block2    = block2_reg;
  assign row_we    = busy && phase_reg;

  // Each row takes two cycles: phase 0 fetches the source, phase 1 writes the target.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    phase_next = phase_reg;
    func_next  = func_reg;
    stage_next = stage_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    last_row   = (func_reg == FN_DROP) ? (row_reg == '0) : (row_reg == LAST_ROW);
    case (state_reg)
      ST_READY: begin
        if (enable) begin
          accept     = 1'b1;
          state_next = ST_RUN;
          func_next  = func;
          stage_next = stage;
          row_next   = (func == FN_DROP) ? LAST_ROW : '0;
          phase_next = 1'b0;
        end
      end
      ST_RUN: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (last_row) begin
            state_next = ST_READY;
            done_next  = 1'b1;
          end else if (func_reg == FN_DROP) begin
            row_next = row_reg - ROW_AW'(1);
          end else begin
            row_next = row_reg + ROW_AW'(1);
          end
        end
      end
      default: state_next = ST_READY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_READY;
      row_reg   <= '0;
      phase_reg <= 1'b0;
      func_reg  <= '0;
      stage_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      phase_reg <= phase_next;
      func_reg  <= func_next;
      stage_reg <= stage_next;
      done_reg  <= done_next;
    end
  end

`ifdef GRID_WRAP_EN
  // The row shifted off the edge is captured before the sweep can overwrite it.
  row_t hold_reg;
  logic first_row;
  assign first_row = (func_reg == FN_DROP) ? (row_reg == LAST_ROW) : (row_reg == '0);
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (busy && !phase_reg && first_row) begin
      hold_reg <= (func_reg == FN_PULL) ? grid[0] : grid[LAST_ROW];
    end
  end
  assign vacant_row = hold_reg;
`else
  assign vacant_row = '0;
`endif

  always_comb begin
    src_row = vacant_row;
    if (func_reg == FN_PULL && row_reg != LAST_ROW) begin
      src_row = grid[row_reg + ROW_AW'(1)];
    end else if (func_reg == FN_DROP && row_reg != '0) begin
      src_row = grid[row_reg - ROW_AW'(1)];
    end
  end

  always_comb begin
    case (func_reg)
      FN_CLEAR: wr_row = '0;
      FN_LOAD:  wr_row = row_t'(rom_data);
      default:  wr_row = buf_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_reg <= '0;
    end else if (busy && !phase_reg) begin
      buf_reg <= src_row;
    end
  end

  // Hit port: only a destroyable cell in range is decremented.
  always_comb begin
    hit_in   = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
    hit_cell = hit_in ? grid[hit_row][hit_col] : '0;
    hit_dec  = hit_valid && hit_ready && (hit_cell != '0) && (hit_cell != CELL_SOLID);
    hit_kill = hit_dec && (hit_cell == CELL_W'(1));
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
        logic [CELL_W-1:0] cell_reg;
        always_ff @(posedge clock) begin
          if (reset) begin
            cell_reg <= '0;
          end else if (row_we && row_reg == ROW_AW'(gi)) begin
            cell_reg <= wr_row[gj];
          end else if (hit_dec && hit_row == ROW_AW'(gi) && hit_col == COL_AW'(gj)) begin
            cell_reg <= cell_reg - CELL_W'(1);
          end
        end
        assign grid[gi][gj] = cell_reg;
      end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_live
      assign live_col[gj] = (wr_row[gj] != '0) && (wr_row[gj] != CELL_SOLID);
    end
  endgenerate

  assign row_pop = CNT_W'($countones(live_col));

  // The published count only changes at sweep end or on a destroying hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg       <= '0;
      remaining_reg <= '0;
      destroyed_reg <= 1'b0;
      cleared_reg   <= 1'b0;
    end else begin
      destroyed_reg <= 1'b0;
      cleared_reg   <= 1'b0;
      if (accept) begin
        acc_reg <= '0;
      end else if (row_we) begin
        acc_reg <= acc_reg + row_pop;
      end
      if (done_next) begin
        remaining_reg <= acc_reg + row_pop;
      end else if (hit_kill) begin
        remaining_reg <= remaining_reg - CNT_W'(1);
        destroyed_reg <= 1'b1;
        cleared_reg   <= (remaining_reg == CNT_W'(1));
      end
    end
  end

  always_comb begin
    rd1_in = (int'(row1) < ROWS) && (int'(col1) < COLS);
    rd2_in = (int'(row2) < ROWS) && (int'(col2) < COLS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      block1_reg <= '0;
      block2_reg <= '0;
    end else begin
      block1_reg <= (busy || !rd1_in) ? '0 : grid[row1][col1];
      block2_reg <= (busy || !rd2_in) ? '0 : grid[row2][col2];
    end
  end

endmodule

// File: tb/tb_block_grid_memory.sv
// Self-checking bench for block_grid_memory: operation table, hand-written corner sequences,
// and random hits/reads/ops compared against a cell-array model of the playfield.
module tb_block_grid_memory;
  localparam int ROWS = 30, COLS = 10, CELL_W = 3, ROW_AW = 5, COL_AW = 4, STG_W = 2, CNT_W = 9;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                   reset, enable, hit_valid;
  logic [1:0]             func;
  logic [STG_W-1:0]       stage, rom_stage;
  logic [ROW_AW-1:0]      row1, row2, hit_row, rom_row;
  logic [COL_AW-1:0]      col1, col2, hit_col;
  logic [CELL_W-1:0]      block1, block2;
  logic                   hit_ready, destroyed, busy, done, cleared;
  logic [COLS*CELL_W-1:0] rom_data;
  logic [CNT_W-1:0]       remaining;

  block_grid_memory dut (
    .clock(clock), .reset(reset), .enable(enable), .func(func), .stage(stage),
    .row1(row1), .col1(col1), .row2(row2), .col2(col2), .block1(block1), .block2(block2),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col), .hit_ready(hit_ready),
    .destroyed(destroyed), .rom_stage(rom_stage), .rom_row(rom_row), .rom_data(rom_data),
    .busy(busy), .done(done), .remaining(remaining), .cleared(cleared)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int model [ROWS][COLS];

  // Stage ROM contents: stage 0 row 1 of ones, stage 1 hashed mix, stage 2 all twos, stage 3 all solid.
  function automatic int rom_val(input int s, input int r, input int c);
    case (s)
      0:       return (r == 1) ? 1 : 0;
      1:       return (3 * r + 5 * c + 1) % 8;
      2:       return 2;
      default: return 7;
    endcase
  endfunction

  function automatic logic [COLS*CELL_W-1:0] rom_line(input int s, input int r);
    logic [COLS*CELL_W-1:0] line;
    line = '0;
    for (int c = 0; c < COLS; c++) line[c*CELL_W +: CELL_W] = CELL_W'(rom_val(s, r, c));
    return line;
  endfunction

  always @(posedge clock) rom_data <= rom_line(int'(rom_stage), int'(rom_row));

  function automatic int model_rem();
    int n;
    n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (model[r][c] >= 1 && model[r][c] <= 6) n++;
    return n;
  endfunction

  function automatic int cell_at(input int r, input int c);
    if (r < ROWS && c < COLS) return model[r][c];
    return 0;
  endfunction

  task automatic model_zero();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 0;
  endtask

  task automatic apply_op(input int f, input int s);
    int nxt [ROWS][COLS];
    int vac;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
`ifdef GRID_WRAP_EN
        vac = (f == 2) ? model[0][c] : model[ROWS-1][c];
`else
        vac = 0;
`endif
        case (f)
          0:       nxt[r][c] = 0;
          1:       nxt[r][c] = rom_val(s, r, c);
          2:       nxt[r][c] = (r < ROWS - 1) ? model[r+1][c] : vac;
          default: nxt[r][c] = (r > 0) ? model[r-1][c] : vac;
        endcase
      end
    end
    model = nxt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic read2(input int r1, input int c1, input int r2, input int c2);
    row1 = ROW_AW'(r1); col1 = COL_AW'(c1); row2 = ROW_AW'(r2); col2 = COL_AW'(c2);
    @(negedge clock);
    check("read1", 32'(block1), cell_at(r1, c1));
    check("read2", 32'(block2), cell_at(r2, c2));
    $display("[TB] read (%0d,%0d)=%0d (%0d,%0d)=%0d", r1, c1, block1, r2, c2, block2);
  endtask

  // Hit (r,c) while port 1 reads the same cell, so the pre-hit value is observed.
  task automatic hit_rd(input int r, input int c, input int r2, input int c2);
    int  pre, pre2, rem_b;
    bit  kill;
    pre   = cell_at(r, c);
    pre2  = cell_at(r2, c2);
    rem_b = model_rem();
    check("hit_ready", 32'(hit_ready), 1);
    hit_valid = 1'b1; hit_row = ROW_AW'(r); hit_col = COL_AW'(c);
    row1 = ROW_AW'(r); col1 = COL_AW'(c); row2 = ROW_AW'(r2); col2 = COL_AW'(c2);
    @(negedge clock);
    hit_valid = 1'b0;
    kill = (pre == 1);
    if (pre != 0 && pre != 7) model[r][c] = pre - 1;
    check("hit_pre_value", 32'(block1), pre);
    check("hit_port2", 32'(block2), pre2);
    check("destroyed", 32'(destroyed), 32'(kill));
    check("cleared", 32'(cleared), 32'(kill && rem_b == 1));
    check("hit_remaining", 32'(remaining), model_rem());
    $display("[TB] hit (%0d,%0d) pre=%0d destroyed=%0d cleared=%0d remaining=%0d",
             r, c, pre, destroyed, cleared, remaining);
  endtask

  task automatic do_op(input int f, input int s, input bit poke);
    int cnt, rem_before;
    rem_before = model_rem();
    func = 2'(f); stage = STG_W'(s); enable = 1'b1;
    @(negedge clock);
    enable = 1'b0; func = ~2'(f); stage = ~STG_W'(s);
    cnt = 0;
    while (busy === 1'b1 && cnt < 4 * ROWS) begin
      if (cnt == 10) check("remaining_hold", 32'(remaining), rem_before);
      if (poke && cnt == 5) begin
        enable = 1'b1; hit_valid = 1'b1; hit_row = 5; hit_col = 4; row1 = 5; col1 = 4;
      end
      if (poke && cnt == 6) begin
        enable = 1'b0; hit_valid = 1'b0;
        check("busy_read", 32'(block1), 0);
      end
      cnt++;
      @(negedge clock);
    end
    check("busy_cycles", cnt, 2 * ROWS);
    check("done_pulse", 32'(done), 1);
    check("rom_stage", 32'(rom_stage), s);
    apply_op(f, s);
    check("op_remaining", 32'(remaining), model_rem());
    $display("[TB] op func=%0d stage=%0d busy=%0d cycles remaining=%0d", f, s, cnt, remaining);
    @(negedge clock);
    check("done_once", 32'(done), 0);
    check("no_restart", 32'(busy), 0);
  endtask

  typedef struct {
    int f; int s; int pr; int pc; int exp_cell; int exp_rem;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tbl[0] = '{1, 2,  5, 4, 2, 300};
    tbl[1] = '{0, 0,  5, 4, 0,   0};
    tbl[2] = '{1, 3, 29, 9, 7,   0};
    tbl[3] = '{1, 0,  1, 3, 1,  10};
    tbl[4] = '{2, 0,  0, 3, 1,  10};
    tbl[5] = '{3, 0,  1, 3, 1,  10};
    tbl[6] = '{3, 0,  2, 9, 1,  10};
    tbl[7] = '{2, 1,  1, 0, 1,  10};

    reset = 1'b1; enable = 1'b0; func = '0; stage = '0; hit_valid = 1'b0;
    hit_row = '0; hit_col = '0; row1 = '0; col1 = '0; row2 = '0; col2 = '0;
    model_zero();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 0);
    check("reset_hit_ready", 32'(hit_ready), 1);
    check("reset_remaining", 32'(remaining), 0);
    check("reset_done", 32'(done), 0);
    check("reset_rom_stage", 32'(rom_stage), 0);
    read2(0, 0, 29, 9);

    // Whole-grid operations with hand-computed expectations.
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].f, tbl[i].s, bit'(i % 2));
      row1 = ROW_AW'(tbl[i].pr); col1 = COL_AW'(tbl[i].pc);
      row2 = ROW_AW'(tbl[i].pr); col2 = COL_AW'(tbl[i].pc);
      @(negedge clock);
      check("tbl_cell1", 32'(block1), tbl[i].exp_cell);
      check("tbl_cell2", 32'(block2), tbl[i].exp_cell);
      check("tbl_remaining", 32'(remaining), tbl[i].exp_rem);
      $display("[TB] vector %0d func=%0d cell=%0d remaining=%0d", i, tbl[i].f, block1, remaining);
    end

    // Double hit on a value-2 brick, then a hit on empty; out-of-range reads.
    do_op(1, 2, 0);
    hit_rd(5, 4, 5, 4);
    hit_rd(5, 4, 0, 0);
    hit_rd(5, 4, 29, 9);
    read2(5, 4, 30, 0);
    read2(0, 10, 31, 15);

    // Indestructible cells ignore hits.
    do_op(1, 3, 0);
    hit_rd(0, 0, 29, 9);
    read2(0, 0, 0, 1);

    // Clear the last row of bricks one by one; cleared fires with the final one.
    do_op(1, 0, 1);
    for (int c = 0; c < COLS; c++) hit_rd(1, c, 1, c);

    // Reset part-way through a DROP.
    do_op(1, 2, 0);
    func = 2'd3; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clock);
    end
    check("drop_running", cnt, 20);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_zero();
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_remaining", 32'(remaining), 0);
    read2(5, 4, 29, 9);
    check("rst_mid_no_done", 32'(done), 0);
    read2(0, 0, 15, 5);

    // Random hits, reads and operations against the model.
    do_op(1, 1, 0);
    for (int it = 0; it < 250; it++) begin
      int a, r;
      a = $urandom_range(0, 19);
      if (a < 12) begin
        hit_rd($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1),
               $urandom_range(0, 31), $urandom_range(0, 15));
      end else if (a < 18) begin
        read2($urandom_range(0, 31), $urandom_range(0, 15),
              $urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
      end else begin
        do_op($urandom_range(0, 3), $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        r = $urandom_range(0, ROWS-1);
        for (int c = 0; c < COLS; c += 2) read2(r, c, (r + 1) % ROWS, c + 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
